// File: rtl/instruction_fetch_stage.sv
// IF stage of the 5-stage MIPS pipeline: owns the PC, drives the instruction
// memory address, fills the IF/ID register and latches a sticky fetch fault.
module instruction_fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned IMEM_BYTES = 512
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  output logic [31:0] imem_address,
  input  logic [31:0] imem_instruction,
  output logic [31:0] if_id_instruction,
  output logic [31:0] if_id_pc_plus4,
  output logic        if_id_valid,
  output logic        fetch_fault,
  output logic [31:0] fetch_count
);

  typedef enum logic {RUN, FAULT} state_t;

  localparam logic [31:0] LAST_WORD = 32'(IMEM_BYTES - 4);

  state_t      state, state_next;
  logic [31:0] pc, pc_next;
  logic [31:0] pc_plus4;
  logic [31:0] instr_q, instr_next;
  logic [31:0] pc4_q, pc4_next;
  logic [31:0] count_q, count_next;
  logic        valid_q, valid_next;
  logic        legal;

  assign pc_plus4 = pc + 32'd4;
  assign legal    = (pc[1:0] == 2'b00) && (pc <= LAST_WORD);

  always_comb begin
    state_next = state;
    pc_next    = pc;
    instr_next = instr_q;
    pc4_next   = pc4_q;
    valid_next = valid_q;
    count_next = count_q;
    case (state)
      RUN: begin
        if (!legal) begin
          // Illegal fetch overrides stall/flush/redirect and parks the PC.
          state_next = FAULT;
          instr_next = '0;
          pc4_next   = '0;
          valid_next = 1'b0;
        end else begin
          if (redirect)   pc_next = redirect_target;
          else if (!stall) pc_next = pc_plus4;

          if (flush) begin
            instr_next = '0;
            pc4_next   = '0;
            valid_next = 1'b0;
          end else if (!stall) begin
            instr_next = imem_instruction;
            pc4_next   = pc_plus4;
            valid_next = 1'b1;
            count_next = count_q + 32'd1;
          end
        end
      end
      FAULT: begin
        instr_next = '0;
        pc4_next   = '0;
        valid_next = 1'b0;
      end
      default: state_next = FAULT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= RUN;
      pc      <= RESET_PC;
      instr_q <= '0;
      pc4_q   <= '0;
      valid_q <= 1'b0;
      count_q <= '0;
    end else begin
      state   <= state_next;
      pc      <= pc_next;
      instr_q <= instr_next;
      pc4_q   <= pc4_next;
      valid_q <= valid_next;
      count_q <= count_next;
    end
  end

  assign imem_address      = pc;
  assign if_id_instruction = instr_q;
  assign if_id_pc_plus4    = pc4_q;
  assign if_id_valid       = valid_q;
  assign fetch_fault       = (state == FAULT);
  assign fetch_count       = count_q;

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Vector-table bench for instruction_fetch_stage: each row is driven before an
// edge, its expectation queued, then popped and compared after the edge.
module tb_instruction_fetch_stage;

  typedef struct {
    logic        rst;
    logic        stall;
    logic        flush;
    logic        redirect;
    logic [31:0] target;
    logic [31:0] exp_pc;
    logic [31:0] exp_instr;
    logic [31:0] exp_pc4;
    logic        exp_valid;
    logic        exp_fault;
    logic [31:0] exp_count;
    logic        chk_pc4;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset, stall, flush, redirect;
  logic [31:0] redirect_target;
  logic [31:0] imem_address, imem_instruction;
  logic [31:0] if_id_instruction, if_id_pc_plus4, fetch_count;
  logic        if_id_valid, fetch_fault;

  int unsigned checks   = 0;
  int unsigned failures = 0;

  vec_t vecs[$];
  vec_t exp_q[$];

  always #5 clk = ~clk;

  // Memory word k at byte 4k holds 0x1000_0000 + k.
  assign imem_instruction = 32'h1000_0000 + {2'b00, imem_address[31:2]};

  instruction_fetch_stage #(
    .RESET_PC  (32'h0000_0000),
    .IMEM_BYTES(512)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .stall            (stall),
    .flush            (flush),
    .redirect         (redirect),
    .redirect_target  (redirect_target),
    .imem_address     (imem_address),
    .imem_instruction (imem_instruction),
    .if_id_instruction(if_id_instruction),
    .if_id_pc_plus4   (if_id_pc_plus4),
    .if_id_valid      (if_id_valid),
    .fetch_fault      (fetch_fault),
    .fetch_count      (fetch_count)
  );

  task automatic add(input logic r, input logic s, input logic f, input logic rd,
                     input logic [31:0] tgt, input logic [31:0] pc,
                     input logic [31:0] instr, input logic [31:0] pc4,
                     input logic v, input logic flt, input logic [31:0] cnt,
                     input logic cpc4 = 1'b1);
    vec_t x;
    x.rst = r; x.stall = s; x.flush = f; x.redirect = rd; x.target = tgt;
    x.exp_pc = pc; x.exp_instr = instr; x.exp_pc4 = pc4; x.exp_valid = v;
    x.exp_fault = flt; x.exp_count = cnt; x.chk_pc4 = cpc4;
    vecs.push_back(x);
  endtask

  task automatic chk32(input string name, input int unsigned idx,
                       input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s row %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  initial begin
    vec_t e;
    reset = 1'b1; stall = 1'b0; flush = 1'b0; redirect = 1'b0;
    redirect_target = '0;

    // Free run after reset
    add(1,0,0,0,0,        32'h0,  32'h0,          32'h0,  0,0,0);
    add(0,0,0,0,0,        32'h4,  32'h1000_0000,  32'h4,  1,0,1);
    add(0,0,0,0,0,        32'h8,  32'h1000_0001,  32'h8,  1,0,2);
    add(0,0,0,0,0,        32'hC,  32'h1000_0002,  32'hC,  1,0,3);
    add(0,0,0,0,0,        32'h10, 32'h1000_0003,  32'h10, 1,0,4);
    // Stall at pc=8 for two cycles, then release
    add(1,0,0,0,0,        32'h0,  32'h0,          32'h0,  0,0,0);
    add(0,0,0,0,0,        32'h4,  32'h1000_0000,  32'h4,  1,0,1);
    add(0,0,0,0,0,        32'h8,  32'h1000_0001,  32'h8,  1,0,2);
    add(0,1,0,0,0,        32'h8,  32'h1000_0001,  32'h8,  1,0,2);
    add(0,1,0,0,0,        32'h8,  32'h1000_0001,  32'h8,  1,0,2);
    add(0,0,0,0,0,        32'hC,  32'h1000_0002,  32'hC,  1,0,3);
    // Redirect + flush at pc=12, then load from the target
    add(0,0,1,1,32'h40,   32'h40, 32'h0,          32'h0,  0,0,3);
    add(0,0,0,0,0,        32'h44, 32'h1000_0010,  32'h44, 1,0,4);
    // stall + redirect + flush together, stall alone, resume
    add(0,1,1,1,32'h80,   32'h80, 32'h0,          32'h0,  0,0,4);
    add(0,1,0,0,0,        32'h80, 32'h0,          32'h0,  0,0,4);
    add(0,0,0,0,0,        32'h84, 32'h1000_0020,  32'h84, 1,0,5);
    // Misaligned redirect: accepted, fault on the following edge
    add(0,0,0,1,32'h1FE,  32'h1FE,32'h1000_0021,  32'h88, 1,0,6);
    add(0,0,0,0,0,        32'h1FE,32'h0,          32'h0,  0,1,6, 1'b0);
    add(0,1,1,1,32'h0,    32'h1FE,32'h0,          32'h0,  0,1,6, 1'b0);
    add(0,0,0,1,32'h40,   32'h1FE,32'h0,          32'h0,  0,1,6, 1'b0);
    add(1,1,0,1,32'h40,   32'h0,  32'h0,          32'h0,  0,0,0);
    // Out-of-range redirect
    add(0,0,0,1,32'h200,  32'h200,32'h1000_0000,  32'h4,  1,0,1);
    add(0,0,1,1,32'h8,    32'h200,32'h0,          32'h0,  0,1,1, 1'b0);
    add(1,0,0,0,0,        32'h0,  32'h0,          32'h0,  0,0,0);
    // Last legal word 0x1FC, then sequential step to 0x200 faults
    add(0,0,0,1,32'h1FC,  32'h1FC,32'h1000_0000,  32'h4,  1,0,1);
    add(0,0,0,0,0,        32'h200,32'h1000_007F,  32'h200,1,0,2);
    add(0,0,0,0,0,        32'h200,32'h0,          32'h0,  0,1,2, 1'b0);
    add(1,0,0,0,0,        32'h0,  32'h0,          32'h0,  0,0,0);
    // Reach pc=0x20 with count 7, stall there, then reset while stalled
    for (int k = 1; k <= 7; k++)
      add(0,0,0,0,0, 32'(4*k), 32'h1000_0000 + 32'(k-1), 32'(4*k), 1,0,32'(k));
    add(0,0,1,0,0,        32'h20, 32'h0,          32'h0,  0,0,7);
    add(0,1,0,0,0,        32'h20, 32'h0,          32'h0,  0,0,7);
    add(1,1,0,0,0,        32'h0,  32'h0,          32'h0,  0,0,0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      reset           = vecs[i].rst;
      stall           = vecs[i].stall;
      flush           = vecs[i].flush;
      redirect        = vecs[i].redirect;
      redirect_target = vecs[i].target;
      exp_q.push_back(vecs[i]);
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL scoreboard row %0d: queue empty", i);
      end else begin
        e = exp_q.pop_front();
        chk32("imem_address", i, imem_address, e.exp_pc);
        chk32("if_id_instruction", i, if_id_instruction, e.exp_instr);
        if (e.chk_pc4) chk32("if_id_pc_plus4", i, if_id_pc_plus4, e.exp_pc4);
        chk32("if_id_valid", i, {31'b0, if_id_valid}, {31'b0, e.exp_valid});
        chk32("fetch_fault", i, {31'b0, fetch_fault}, {31'b0, e.exp_fault});
        chk32("fetch_count", i, fetch_count, e.exp_count);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_stage.md
Name: instruction_fetch_stage

Overview:
- IF stage of the 5-stage MIPS pipeline. Owns the program counter and drives the byte address of the combinational, big-endian, byte-addressed instruction memory.
- Captures the returned 32-bit word into the IF/ID pipeline register and handles stall, flush and redirect from later stages.
- Detects out-of-range or misaligned fetches and enters a sticky fault state.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- IMEM_BYTES, 512, instruction memory size in bytes. A fetch is legal only if pc+3 < IMEM_BYTES.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- stall  input  1  hazard unit: hold PC and IF/ID
- flush  input  1  squash the instruction being written into IF/ID
- redirect  input  1  taken branch/jump resolved downstream
- redirect_target  input  32  new PC when redirect=1
- imem_address  output  32  byte address to instruction memory; equals pc
- imem_instruction  input  32  word returned by instruction memory, same cycle
- if_id_instruction  output  32  registered instruction
- if_id_pc_plus4  output  32  registered pc+4 of that instruction
- if_id_valid  output  1  1 = real instruction, 0 = bubble
- fetch_fault  output  1  sticky fault flag
- fetch_count  output  32  number of valid instructions delivered to IF/ID

Behaviour:
- One clock; reset is synchronous and active-high. All state updates happen on the rising edge of clk.
- Reset has priority over every other input, including mid-fault and mid-stall. On reset:
  - pc=RESET_PC, state=RUN
  - if_id_instruction=0, if_id_pc_plus4=0, if_id_valid=0
  - fetch_fault=0, fetch_count=0
- imem_address=pc, combinational. There is no extra latency: the word fetched in cycle N appears on the IF/ID outputs after edge N.
- legal = (pc[1:0]==0) && (pc <= IMEM_BYTES-4), evaluated on the current pc.
- State RUN, legal fetch, per-edge priority:
  - PC update: redirect, then stall, then sequential.
    - redirect=1: pc<=redirect_target. This wins over stall.
    - else stall=1: pc holds.
    - else: pc<=pc+4, modulo 2^32.
  - IF/ID update: flush, then stall, then load.
    - flush=1: instruction<=0 (NOP), pc_plus4<=0, valid<=0. This wins over stall.
    - else stall=1: all IF/ID fields hold.
    - else: instruction<=imem_instruction, pc_plus4<=pc+4, valid<=1, fetch_count<=fetch_count+1.
  - redirect does not itself squash IF/ID. The downstream stage asserts flush alongside redirect when required.
- State RUN, illegal fetch (not gated by stall; flush and redirect in the same cycle are ignored):
  - next state=FAULT, fetch_fault<=1
  - IF/ID loads a bubble (instruction=0, valid=0)
  - pc holds at the faulting address
  - fetch_count unchanged
- State FAULT:
  - pc, fetch_fault=1 and fetch_count are frozen.
  - IF/ID continuously holds a bubble.
  - stall, flush and redirect are ignored.
  - The only exit is reset.
- fetch_count wraps from 32'hFFFF_FFFF to 0.
- A redirect to an illegal target is accepted. The fault is raised on the following edge, when that pc is evaluated.

Test Plan:
- Reset, then 4 free-run cycles with memory word k at byte 4k = 32'h1000_0000+k -> IF/ID delivers 0x1000_0000..0x1000_0003 with pc_plus4 = 4, 8, 12, 16, valid=1, fetch_count=4, imem_address reaches 16.
- stall=1 for 2 cycles at pc=8 -> pc stays 8 and IF/ID holds the word from pc=4 with pc_plus4=8. After release, the next edge loads the pc=8 word with pc_plus4=12.
- redirect=1, redirect_target=0x40, flush=1 at pc=12 -> next edge: pc=0x40, if_id_valid=0, instruction=0, fetch_count unchanged. The following edge loads the word at 0x40 with pc_plus4=0x44.
- stall=1, redirect=1, flush=1 in the same cycle -> pc takes target (redirect beats stall) and IF/ID becomes a bubble (flush beats stall).
- redirect_target=0x1FE (misaligned), then 0x200 (out of range, after reset) -> fetch_fault=1 one edge after pc reaches the bad value, pc frozen, valid=0. Subsequent redirect and stall are ignored. reset restores pc=0 and fetch_fault=0.
- Assert reset while stalled at pc=0x20 with fetch_count=7 -> all outputs return to reset values on that edge.
